// File: rtl/chroma_vga_pkg.sv
// chroma_vga_pkg
//    Shared definitions for the chroma-key VGA transmit path: pixel field
//    positions inside the 30-bit composited word, default 640x480@60 timing,
//    the transmit state encoding and the colour-bar test pattern.
package chroma_vga_pkg;

   // Composited pixel layout {R, G, B}, 10 bits per component
   localparam int R_MSB   = 29;
   localparam int R_LSB   = 20;
   localparam int G_MSB   = 19;
   localparam int G_LSB   = 10;
   localparam int B_MSB   = 9;
   localparam int B_LSB   = 0;
   localparam int PIX_W   = 30;
   localparam int ENTRY_W = PIX_W + 1;   // FIFO entry {sof, pixel}

   // Default 640x480 raster
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      ARMED    = 2'd1,
      RUN      = 2'd2
   } tx_state_e;

   // Colour bars: one {R,G,B} on/off triple per bar, leftmost bar in the MSBs
   localparam int         NUM_BARS  = 8;
   localparam logic [9:0] BAR_ON    = 10'h3FF;
   localparam logic [23:0] BAR_MASKS = {3'b111,   // white
                                        3'b110,   // yellow
                                        3'b011,   // cyan
                                        3'b010,   // green
                                        3'b101,   // magenta
                                        3'b100,   // red
                                        3'b001,   // blue
                                        3'b000};  // black

   function automatic logic [PIX_W-1:0] bar_pixel(input logic [2:0] idx);
      int         sel;
      logic [2:0] m;
      sel = 3 * (7 - int'(idx));
      m   = BAR_MASKS[sel +: 3];
      return {(m[2] ? BAR_ON : 10'h000),
              (m[1] ? BAR_ON : 10'h000),
              (m[0] ? BAR_ON : 10'h000)};
   endfunction

endpackage

// File: rtl/chroma_pix_fifo.sv
// chroma_pix_fifo
//    Small synchronous FIFO with show-ahead read data and a flush input.
//    A write in the same cycle as a flush survives as the only entry, so a
//    start-of-frame word arriving while the queue is being discarded is kept.
//
// Ports
//    clk_i      clock
//    srst_i     synchronous active-high reset (empties the FIFO)
//    flush_i    discard all held entries
//    wr_en_i    write wr_data_i
//    wr_data_i  entry to write
//    rd_en_i    pop the head entry (ignored while empty)
//    rd_data_o  current head entry
//    full_o     DEPTH entries held
//    empty_o    no entries held
module chroma_pix_fifo #(
   parameter int WIDTH = 31,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             flush_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW-1:0]    wr_addr;
   logic [AW:0]      count_q, count_d;
   logic             do_wr, do_rd;

   assign full_o    = (count_q == FULL_CNT);
   assign empty_o   = (count_q == '0);
   assign do_rd     = rd_en_i && !empty_o;
   // A write at full is only legal when a pop or flush frees a slot
   assign do_wr     = wr_en_i && (!full_o || do_rd || flush_i);
   assign rd_data_o = mem_q[rptr_q];

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      wr_addr = wptr_q;
      if (flush_i) begin
         rptr_d  = '0;
         wr_addr = '0;
         wptr_d  = do_wr ? AW'(1) : '0;
         count_d = do_wr ? (AW+1)'(1) : '0;
      end else begin
         if (do_wr) wptr_d = wptr_q + 1'b1;
         if (do_rd) rptr_d = rptr_q + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid
   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_addr] <= wr_data_i;
   end

endmodule

// File: rtl/chroma_vga_tx.sv
// chroma_vga_tx
//    Output end of the chroma-key pixel path. Composited 30-bit pixels enter
//    through a valid/ready handshake into a FIFO; a free-running raster
//    generator pops one word per active pixel and drives the VGA DAC pins.
//    Frames are aligned on a start-of-frame tag; an empty FIFO during active
//    video or a misplaced tag drops back to waiting for the next tag.
//
//    Optional build macro CHROMA_TX_TESTPAT_EN adds iTestPat, which replaces
//    active video with 8 colour bars and holds the path idle.
//
// Ports
//    iCLK27        pixel clock
//    iRST          synchronous active-high reset
//    iPixel        composited pixel {R,G,B}
//    iSOF          iPixel is pixel (0,0) of a frame
//    iValid        iPixel/iSOF valid
//    iTestPat      colour-bar override (only with CHROMA_TX_TESTPAT_EN)
//    oReady        a word is accepted this cycle when iValid is high
//    oVGA_R/G/B    colour, zero outside active video
//    oVGA_HS/VS    syncs, active low
//    oVGA_BLANK_N  high during active video
//    oUnderflow    sticky, set when the FIFO ran dry during active video
module chroma_vga_tx
   import chroma_vga_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        iCLK27,
   input  logic        iRST,
   input  logic [29:0] iPixel,
   input  logic        iSOF,
   input  logic        iValid,
`ifdef CHROMA_TX_TESTPAT_EN
   input  logic        iTestPat,
`endif
   output logic        oReady,
   output logic [9:0]  oVGA_R,
   output logic [9:0]  oVGA_G,
   output logic [9:0]  oVGA_B,
   output logic        oVGA_HS,
   output logic        oVGA_VS,
   output logic        oVGA_BLANK_N,
   output logic        oUnderflow
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

   tx_state_e        state_q, state_d;
   logic [HW-1:0]    hcnt_q, hcnt_d;
   logic [VW-1:0]    vcnt_q, vcnt_d;
   logic             ready_en_q;
   logic [PIX_W-1:0] rgb_q, rgb_d;
   logic             hs_q, vs_q, blank_n_q;
   logic             underflow_q, underflow_d;

   logic               active_c, origin_c, hs_c, vs_c;
   logic               ready_c, xfer_c, pop_slot_c;
   logic               fifo_flush, fifo_wr, fifo_rd, fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] fifo_head;

   // ---------------- raster counters (free-running) ----------------
   always_comb begin
      hcnt_d = hcnt_q + 1'b1;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end
   end

   assign active_c = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
   assign origin_c = (hcnt_q == '0) && (vcnt_q == '0);
   assign hs_c     = !((hcnt_q >= HS_BEGIN) && (hcnt_q < HS_END));
   assign vs_c     = !((vcnt_q >= VS_BEGIN) && (vcnt_q < VS_END));

   // ---------------- handshake ----------------
   // ready_en_q keeps oReady low for the cycle right after reset
   assign ready_c = ready_en_q && ((state_q == WAIT_SOF) || !fifo_full);
   assign oReady  = ready_c;
   assign xfer_c  = iValid && ready_c;

   // Pops happen on every active pixel while running, plus the origin pixel
   // that takes an armed frame live.
   assign pop_slot_c = ((state_q == RUN) && active_c) ||
                       ((state_q == ARMED) && origin_c);

`ifdef CHROMA_TX_TESTPAT_EN
   logic [HW-1:0] bar_idx_c;
   assign bar_idx_c = hcnt_q / HW'(H_ACTIVE / NUM_BARS);
`endif

   // ---------------- transmit FSM ----------------
   always_comb begin
      state_d     = state_q;
      underflow_d = underflow_q;
      rgb_d       = '0;
      fifo_flush  = 1'b0;
      fifo_rd     = 1'b0;
      fifo_wr     = 1'b0;

      if (pop_slot_c) begin
         if (fifo_empty) begin
            underflow_d = 1'b1;
            fifo_flush  = 1'b1;
            state_d     = WAIT_SOF;
         end else begin
            fifo_rd = 1'b1;
            // The tag must sit exactly on the origin pixel, and only there
            if (fifo_head[ENTRY_W-1] != origin_c) begin
               fifo_flush = 1'b1;
               state_d    = WAIT_SOF;
            end else begin
               state_d = RUN;
               rgb_d   = fifo_head[PIX_W-1:0];
            end
         end
      end

      // Decided against the post-pop state so that a tagged word arriving in
      // the same cycle as a resync flush starts the next frame.
      if (xfer_c) begin
         if (state_d == WAIT_SOF) begin
            if (iSOF) begin
               fifo_wr = 1'b1;
               state_d = ARMED;
            end
         end else begin
            fifo_wr = 1'b1;
         end
      end

`ifdef CHROMA_TX_TESTPAT_EN
      if (iTestPat) begin
         state_d     = WAIT_SOF;
         underflow_d = underflow_q;
         fifo_flush  = 1'b1;
         fifo_rd     = 1'b0;
         fifo_wr     = 1'b0;
         rgb_d       = active_c ? bar_pixel(bar_idx_c[2:0]) : '0;
      end
`endif
   end

   always_ff @(posedge iCLK27) begin
      if (iRST) begin
         state_q     <= WAIT_SOF;
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         ready_en_q  <= 1'b0;
         rgb_q       <= '0;
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         blank_n_q   <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         ready_en_q  <= 1'b1;
         rgb_q       <= rgb_d;
         hs_q        <= hs_c;
         vs_q        <= vs_c;
         blank_n_q   <= active_c;
         underflow_q <= underflow_d;
      end
   end

   chroma_pix_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (iCLK27),
      .srst_i    (iRST),
      .flush_i   (fifo_flush),
      .wr_en_i   (fifo_wr),
      .wr_data_i ({iSOF, iPixel}),
      .rd_en_i   (fifo_rd),
      .rd_data_o (fifo_head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign oVGA_R       = rgb_q[R_MSB:R_LSB];
   assign oVGA_G       = rgb_q[G_MSB:G_LSB];
   assign oVGA_B       = rgb_q[B_MSB:B_LSB];
   assign oVGA_HS      = hs_q;
   assign oVGA_VS      = vs_q;
   assign oVGA_BLANK_N = blank_n_q;
   assign oUnderflow   = underflow_q;

endmodule

// File: tb/tb_chroma_vga_tx.sv
// tb_chroma_vga_tx
//    Directed/randomised bench for chroma_vga_tx on a reduced raster
//    (16x6 active, 24x10 total) so whole frames run quickly.
`timescale 1ns/1ps
module tb_chroma_vga_tx;

   localparam int HA  = 16, HFP = 2, HSY = 3, HBP = 3;
   localparam int VA  = 6,  VFP = 1, VSY = 2, VBP = 1;
   localparam int FD  = 16;
   localparam int HT  = HA + HFP + HSY + HBP;
   localparam int VT  = VA + VFP + VSY + VBP;
   localparam int FT  = HT * VT;
   localparam int NPIX = HA * VA;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [29:0] pix = '0;
   logic        sof = 1'b0;
   logic        valid = 1'b0;
   logic        ready, hs, vs, blank_n, uf;
   logic [9:0]  r, g, b;
`ifdef CHROMA_TX_TESTPAT_EN
   logic        tp = 1'b0;
`endif

   always #5 clk = ~clk;

   chroma_vga_tx #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .FIFO_DEPTH(FD)
   ) dut (
      .iCLK27       (clk),
      .iRST         (rst),
      .iPixel       (pix),
      .iSOF         (sof),
      .iValid       (valid),
`ifdef CHROMA_TX_TESTPAT_EN
      .iTestPat     (tp),
`endif
      .oReady       (ready),
      .oVGA_R       (r),
      .oVGA_G       (g),
      .oVGA_B       (b),
      .oVGA_HS      (hs),
      .oVGA_VS      (vs),
      .oVGA_BLANK_N (blank_n),
      .oUnderflow   (uf)
   );

   int checks   = 0;
   int failures = 0;

   // stimulus source: words still to be offered, {sof, pixel}
   logic [30:0] tx_q[$];
   bit          send_en  = 1'b1;
   bit          gap_rand = 1'b0;

   // reference model: accepted-but-not-shown words and frame lock status
   logic [30:0] ref_q[$];
   bit          model_ok = 1'b0;
   bit          ready_ok, locked, showing, ref_uf, shown_org;
   int          t = 0;
   logic [29:0] exp_rgb;
   logic        exp_hs, exp_vs, exp_blank;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, want);
      end
   endtask

   function automatic logic [29:0] bar_colour(input int h);
      int idx;
      bit rr, gg, bb;
      idx = h / (HA / 8);
      rr  = (idx == 0) || (idx == 1) || (idx == 4) || (idx == 5);
      gg  = (idx < 4);
      bb  = (idx % 2) == 0;
      return {(rr ? 10'h3FF : 10'h0), (gg ? 10'h3FF : 10'h0), (bb ? 10'h3FF : 10'h0)};
   endfunction

   task automatic load_frame(input int n, input int bad_idx, input logic [29:0] first_pix);
      for (int i = 0; i < n; i++) begin
         logic [29:0] p;
         p = (i == 0) ? first_pix : 30'($urandom);
         tx_q.push_back({((i == 0) || (i == bad_idx)), p});
      end
   endtask

   // One clock: drive inputs, check oReady, advance the model, check outputs
   task automatic step();
      int          h, v;
      bit          act, org, exp_ready, xfer;
      logic [30:0] e;
      h   = t % HT;
      v   = (t / HT) % VT;
      act = (h < HA) && (v < VA);
      org = (h == 0) && (v == 0);

      valid = !rst && send_en && (tx_q.size() > 0) &&
              (!gap_rand || ($urandom_range(3) != 0));
      {sof, pix} = (tx_q.size() > 0) ? tx_q[0] : 31'h0;

      exp_ready = ready_ok && (!locked || (ref_q.size() < FD));
      if (model_ok) chk("ready", {31'b0, ready}, {31'b0, exp_ready});
      xfer      = valid && exp_ready;
      shown_org = 1'b0;

      if (rst) begin
         t = 0; ready_ok = 0; locked = 0; showing = 0; ref_uf = 0;
         ref_q.delete();
         exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b0;
         model_ok = 1'b1;
      end else begin
         exp_rgb = '0;
`ifdef CHROMA_TX_TESTPAT_EN
         if (tp) begin
            ref_q.delete();
            locked  = 0;
            showing = 0;
            if (act) exp_rgb = bar_colour(h);
         end else
`endif
         begin
            if ((showing && act) || (locked && !showing && org)) begin
               if (ref_q.size() == 0) begin
                  ref_uf = 1; locked = 0; showing = 0;
               end else begin
                  e = ref_q.pop_front();
                  if (e[30] != org) begin
                     ref_q.delete(); locked = 0; showing = 0;
                  end else begin
                     showing   = 1;
                     exp_rgb   = e[29:0];
                     shown_org = org;
                  end
               end
            end
            if (xfer) begin
               if (locked) ref_q.push_back({sof, pix});
               else if (sof) begin
                  ref_q.push_back({sof, pix});
                  locked = 1;
               end
            end
         end
         exp_hs    = !((h >= HA + HFP) && (h < HA + HFP + HSY));
         exp_vs    = !((v >= VA + VFP) && (v < VA + VFP + VSY));
         exp_blank = act;
         t++;
         ready_ok = 1;
      end
      if (xfer) void'(tx_q.pop_front());

      @(posedge clk);
      #1;
      if (model_ok) begin
         chk("rgb",     {2'b0, r, g, b}, {2'b0, exp_rgb});
         chk("hs",      {31'b0, hs},      {31'b0, exp_hs});
         chk("vs",      {31'b0, vs},      {31'b0, exp_vs});
         chk("blank_n", {31'b0, blank_n}, {31'b0, exp_blank});
         chk("uflow",   {31'b0, uf},      {31'b0, ref_uf});
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      tx_q.delete();
   endtask

   initial begin
      int  hs_low, vs_low, stall;
      bit  got_red;

      // ---- A: junk words, red first pixel, two frames, FIFO back-pressure
      do_reset();
      chk("rst_ready", {31'b0, ready}, 32'd0);
      chk("rst_hs",    {31'b0, hs},    32'd1);
      for (int i = 0; i < 5; i++) tx_q.push_back({1'b0, 30'($urandom)});
      load_frame(NPIX, -1, 30'h3FF00000);
      load_frame(NPIX, -1, 30'($urandom));
      hs_low = 0; vs_low = 0; stall = 0; got_red = 0;
      for (int i = 0; i < 700; i++) begin
         step();
         if (i < FT) begin
            hs_low += (hs == 1'b0) ? 1 : 0;
            vs_low += (vs == 1'b0) ? 1 : 0;
         end
         if (i > 0 && !ready) stall++;
         if (shown_org && !got_red) begin
            chk("red00", {2'b0, r, g, b}, {2'b0, 30'h3FF00000});
            got_red = 1;
         end
      end
      chk("hs_low_cnt", 32'(hs_low), 32'(HSY * VT));
      chk("vs_low_cnt", 32'(vs_low), 32'(VSY * HT));
      chk("fifo_stall", {31'b0, (stall > 0)}, 32'd1);
      chk("uf_A_clear", {31'b0, uf}, 32'd0);
      for (int i = 0; i < 60; i++) step();
      chk("uf_A_end", {31'b0, uf}, 32'd1);

      // ---- B: source stops after 20 pixels, then recovers on a new frame
      do_reset();
      load_frame(20, -1, 30'($urandom));
      for (int i = 0; i < 300; i++) step();
      chk("uf_B_set", {31'b0, uf}, 32'd1);
      load_frame(NPIX, -1, 30'($urandom));
      load_frame(NPIX, -1, 30'($urandom));
      for (int i = 0; i < 500; i++) step();
      chk("uf_B_sticky", {31'b0, uf}, 32'd1);

      // ---- C: stray SOF on word 50 forces a resync without underflow
      do_reset();
      load_frame(NPIX, 50, 30'($urandom));
      load_frame(NPIX, -1, 30'($urandom));
      load_frame(NPIX, -1, 30'($urandom));
      for (int i = 0; i < 900; i++) step();
      chk("uf_C_clear", {31'b0, uf}, 32'd0);

      // ---- D: random source gaps, then a one-cycle reset mid-line
      do_reset();
      gap_rand = 1'b1;
      for (int f = 0; f < 4; f++) load_frame(NPIX, -1, 30'($urandom));
      for (int i = 0; i < 500; i++) step();
      for (int k = 0; (k < HT) && ((t % HT) != 7); k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_rgb",   {2'b0, r, g, b}, 32'd0);
      chk("mid_rst_hs",    {31'b0, hs},      32'd1);
      chk("mid_rst_vs",    {31'b0, vs},      32'd1);
      chk("mid_rst_blank", {31'b0, blank_n}, 32'd0);
      chk("mid_rst_ready", {31'b0, ready},   32'd0);
      chk("mid_rst_uf",    {31'b0, uf},      32'd0);
      for (int i = 0; i < 500; i++) step();
      gap_rand = 1'b0;

`ifdef CHROMA_TX_TESTPAT_EN
      // ---- E: colour bars
      do_reset();
      tp = 1'b1;
      load_frame(NPIX, -1, 30'($urandom));
      for (int i = 0; i < FT; i++) begin
         step();
         if (((t - 1) % FT) == 3)
            chk("bar_yellow", {2'b0, r, g, b}, {2'b0, 10'h3FF, 10'h3FF, 10'h0});
      end
      tp = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
